fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
Parametrised N-digit multiplexed 7-segment scan controller. It is the successor to the fixed 4-digit FND driver in the watch datapath. It adds:
- generic digit count and timing
- double-buffered display data, committed at frame boundaries (no tearing)
- per-digit decimal point and blink masks
- leading-zero suppression
- 16-level PWM brightness

It sits between the time/UART formatting logic and the board FND pins.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
SCAN_HZ, 1_000, digit slots per second (frame rate = SCAN_HZ/NUM_DIGITS)
NUM_DIGITS, 4, number of digits, 2..8
BLINK_HZ, 2, blink toggle pairs per second (phase toggles at 2*BLINK_HZ)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits  in  4*NUM_DIGITS  BCD nibble per digit; nibble 0 = rightmost digit
dp_mask  in  NUM_DIGITS  1 = decimal point on for that digit
blink_mask  in  NUM_DIGITS  1 = digit blinks (blanked in off phase, including dp)
lz_en  in  1  1 = leading-zero suppression enabled
brightness  in  4  on-time per slot = (brightness+1)/16
load  in  1  single-cycle strobe; captures digits/dp_mask/blink_mask/lz_en into the pending buffer
fnd_font  out  8  active-low segments, bit7 = dp, bits6..0 = g..a
fnd_comm  out  NUM_DIGITS  active-low digit enables, one-hot-low
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset values:
  - fnd_font = 8'hFF; fnd_comm = all 1s; frame_done = 0.
  - Internal state: digit index 0, sub-tick/PWM counters 0, pending and active buffers all 0, pending_valid 0, blink phase 0 (visible).
- Timing:
  - SUB_DIV = CLK_HZ/(SCAN_HZ*16) clocks per sub-tick; 16 sub-ticks = one digit slot.
  - pwm_cnt (4 bit) counts sub-ticks within a slot.
  - At the end of sub-tick 15, digit index advances (mod NUM_DIGITS) and pwm_cnt wraps to 0.
  - BLINK_DIV = CLK_HZ/(2*BLINK_HZ) clocks per blink-phase toggle; this counter is free-running and independent of scan.
- Buffering:
  - load captures all inputs into pending and sets pending_valid. A load while pending_valid is already set overwrites pending (last load wins).
  - When the index wraps from NUM_DIGITS-1 to 0, frame_done pulses for 1 clk. In the same clk, if pending_valid, pending copies to active and pending_valid clears.
  - If load and the commit occur in the same clk, the committed copy is the old pending. The new load data stays pending for the next frame.
  - brightness is not buffered; it is sampled live each slot.
- Digit decode (from active buffer, current index i):
  - nibble 0..9 gives the standard segments (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dp bit included).
  - nibble A..F gives segments blank; dp still follows dp_mask.
  - dp bit7 = ~dp_mask[i].
- Leading-zero suppression: with lz_en, digit i is blanked (segments and dp) when all digits at positions ≥ i are 0 and i ≠ 0. Digit 0 is never suppressed.
- Blink: when blink_mask[i] and blink phase = 1, the digit is fully blank (font FF, comm still scans).
- PWM: fnd_comm[i] is driven low only when pwm_cnt ≤ brightness; otherwise all comm = 1 and font = FF.
- Anti-ghost: during pwm_cnt == 15 of every slot, all comm are forced high regardless of brightness. Maximum duty is therefore 15/16.
- Outputs are registered: a 1-clk latency from internal index/pwm/buffer state to the pins. No glitches between slots.
- Reset mid-frame: immediate blank; the pending load is discarded.

Decomposition:
- Shared package fnd_pkg:
  - seg_lut function (nibble → 7 segments)
  - constant SEG_BLANK = 8'hFF
  - localparam computations SUB_DIV and BLINK_DIV, with an elaboration error if either < 1
- One natural sub-module: fnd_tick_gen (parametrised divider producing a one-clk enable). It is instantiated twice: once for the sub-tick, once for the blink phase.

Test Plan:
All scenarios use sim parameters CLK_HZ=1600, SCAN_HZ=10, NUM_DIGITS=4, BLINK_HZ=1. This gives SUB_DIV=10, 160 clk per slot, blink toggle every 800 clk.
1. Reset release, no load → fnd_font=FF and fnd_comm=1111 held, frame_done pulses every 640 clk.
2. load digits=16'h1234, dp_mask=0100, brightness=15 → from next frame the comm sequence is 1110, 1101, 1011, 0111. Fonts are 99, B0, 24 (dp on), F9, each low for 150 of 160 clk.
3. digits=16'h0070, lz_en=1 → digit3 blank, digit2 blank, digit1 F8, digit0 C0. With lz_en=0, digit3 = C0.
4. brightness=0 → each comm low exactly 10 clk per 160-clk slot, font FF otherwise.
5. blink_mask=0001, digits=16'h0005 → digit0 toggles between 92 and FF every 800 clk; the other digits are steady.
6. load 16'h1111 mid-frame, then load 16'h2222 5 clk later, before the wrap → the next frame shows 2222. A load coincident with the frame_done clk appears one frame later.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// segment font lookup, blank pattern and divider computations.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a segments for a BCD nibble; non-decimal codes stay dark.
    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Clocks per PWM sub-tick; sixteen sub-ticks make one digit slot.
    function automatic int calc_sub_div(input int clk_hz, input int scan_hz);
        return clk_hz / (scan_hz * 16);
    endfunction

    // Clocks per blink phase toggle.
    function automatic int calc_blink_div(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Display data and FND pin bundle between the formatting logic (master)
// and the scan controller (slave).
interface fnd_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_en;
    logic [3:0]              brightness;
    logic                    load;
    logic [7:0]              fnd_font;
    logic [NUM_DIGITS-1:0]   fnd_comm;
    logic                    frame_done;

    modport master (
        output digits, dp_mask, blink_mask, lz_en, brightness, load,
        input  fnd_font, fnd_comm, frame_done
    );

    modport slave (
        input  digits, dp_mask, blink_mask, lz_en, brightness, load,
        output fnd_font, fnd_comm, frame_done
    );
endinterface

// File: rtl/fnd_tick_gen.sv
// Down-counting divider that emits a one-clock enable every DIV clocks.
module fnd_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count down to zero, reload on terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= RELOAD;
        else if (cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/fnd_scan_controller.sv
// N-digit multiplexed 7-segment scan controller with double-buffered
// display data, leading-zero suppression, blink and 16-level PWM.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_HZ   = 2
) (
    input logic                   clk,
    input logic                   reset,
    fnd_scan_controller_if.slave  bus
);
    localparam int SUB_DIV   = calc_sub_div(CLK_HZ, SCAN_HZ);
    localparam int BLINK_DIV = calc_blink_div(CLK_HZ, BLINK_HZ);
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if (SUB_DIV < 1) begin : g_bad_sub_div
        $error("fnd_scan_controller: SUB_DIV must be at least 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("fnd_scan_controller: BLINK_DIV must be at least 1");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("fnd_scan_controller: NUM_DIGITS must be 2..8");
    end

    logic                    sub_tick;
    logic                    blink_tick;
    logic [3:0]              pwm_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    blink_phase;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blink, act_blink;
    logic                    pend_lz, act_lz;
    logic                    pend_valid, act_valid;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    upper_zero;
    logic                    slot_on;
    logic                    blank;
    logic [7:0]              font_nxt, font_q;
    logic [NUM_DIGITS-1:0]   comm_nxt, comm_q;
    logic                    frame_done_q;

    fnd_tick_gen #(.DIV(SUB_DIV)) u_sub_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (sub_tick)
    );

    fnd_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (blink_tick)
    );

    assign wrap = sub_tick && (pwm_cnt == 4'hF) && (idx == LAST_IDX);

    // Sub-tick position within the slot and the digit being scanned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= 4'h0;
            idx     <= '0;
        end else if (sub_tick) begin
            pwm_cnt <= pwm_cnt + 4'h1;
            if (pwm_cnt == 4'hF)
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Free-running blink phase, independent of the scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink_phase <= 1'b0;
        else if (blink_tick)
            blink_phase <= ~blink_phase;
    end

    // Pending/active double buffer; commit only at the frame wrap so a
    // frame never mixes old and new data. A load on the wrap clock stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blink  <= '0;
            pend_lz     <= 1'b0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blink   <= '0;
            act_lz      <= 1'b0;
            act_valid   <= 1'b0;
        end else begin
            if (wrap && pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_blink  <= pend_blink;
                act_lz     <= pend_lz;
                act_valid  <= 1'b1;
            end
            if (bus.load) begin
                pend_digits <= bus.digits;
                pend_dp     <= bus.dp_mask;
                pend_blink  <= bus.blink_mask;
                pend_lz     <= bus.lz_en;
                pend_valid  <= 1'b1;
            end else if (wrap) begin
                pend_valid  <= 1'b0;
            end
        end
    end

    // Decode the current digit into next pin values; dark until a frame has been committed.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                cur_nib   = act_digits[i*4 +: 4];
                cur_dp    = act_dp[i];
                cur_blink = act_blink[i];
            end
            if (IDX_W'(i) >= idx && act_digits[i*4 +: 4] != 4'h0)
                upper_zero = 1'b0;
        end

        slot_on  = (pwm_cnt <= bus.brightness) && (pwm_cnt != 4'hF);
        blank    = (act_lz && (idx != '0) && upper_zero) || (cur_blink && blink_phase);
        font_nxt = SEG_BLANK;
        comm_nxt = '1;
        if (act_valid && slot_on) begin
            comm_nxt = ~(NUM_DIGITS'(1) << idx);
            if (!blank)
                font_nxt = {~cur_dp, seg_lut(cur_nib)};
        end
    end

    // Register the pins so slot changes never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_q       <= SEG_BLANK;
            comm_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            font_q       <= font_nxt;
            comm_q       <= comm_nxt;
            frame_done_q <= wrap;
        end
    end

    assign bus.fnd_font   = font_q;
    assign bus.fnd_comm   = comm_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: time-based reference model of slots, frames, blink
// phase and the load/commit buffer, compared against the pins every clock.
module tb_fnd_scan_controller;
    localparam int N     = 4;
    localparam int SUBT  = 10;
    localparam int SLOT  = 160;
    localparam int FRAME = 640;
    localparam int PHASE = 800;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_controller_if #(.NUM_DIGITS(N)) bus ();

    fnd_scan_controller #(
        .CLK_HZ     (1600),
        .SCAN_HZ    (10),
        .NUM_DIGITS (N),
        .BLINK_HZ   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          edge_no;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
    } load_t;

    load_t      log_q[$];
    int         n = 0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] bright = 4'hF;

    function automatic logic [7:0] seg_ref(input logic [3:0] v);
        case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected pins after clock edge number nn since reset release.
    function automatic void model(input int nn, input logic [3:0] br,
                                  output logic [7:0] f, output logic [3:0] c,
                                  output logic fd);
        int    e, idx, sub, ph, m;
        bit    found, lzb, blb;
        load_t cur;
        e     = nn - 1;
        fd    = (nn > 0) && (nn % FRAME == 0);
        f     = 8'hFF;
        c     = 4'hF;
        idx   = (e / SLOT) % N;
        sub   = (e % SLOT) / SUBT;
        ph    = (e / PHASE) % 2;
        m     = e / FRAME;
        found = 0;
        cur   = '{0, 16'h0, 4'h0, 4'h0, 1'b0};
        if (m >= 1)
            foreach (log_q[k])
                if (log_q[k].edge_no <= FRAME * m - 1) begin
                    cur   = log_q[k];
                    found = 1;
                end
        if (found && sub <= int'(br) && sub != 15) begin
            c   = 4'hF & ~(4'b0001 << idx);
            lzb = cur.lz && idx != 0 && ((cur.d >> (4 * idx)) == 16'h0);
            blb = cur.bl[idx] && ph == 1;
            if (!lzb && !blb)
                f = seg_ref(cur.d[4*idx +: 4]) & (cur.dp[idx] ? 8'h7F : 8'hFF);
        end
    endfunction

    task automatic step();
        logic [7:0] ef;
        logic [3:0] ec;
        logic       efd;
        @(posedge clk);
        n++;
        if (bus.load)
            log_q.push_back('{n, bus.digits, bus.dp_mask, bus.blink_mask, bus.lz_en});
        @(negedge clk);
        model(n, bright, ef, ec, efd);
        checks++;
        assert (bus.fnd_font === ef) else begin
            failures++;
            $error("FAIL font n=%0d observed=%h expected=%h", n, bus.fnd_font, ef);
        end
        checks++;
        assert (bus.fnd_comm === ec) else begin
            failures++;
            $error("FAIL comm n=%0d observed=%b expected=%b", n, bus.fnd_comm, ec);
        end
        checks++;
        assert (bus.frame_done === efd) else begin
            failures++;
            $error("FAIL frame_done n=%0d observed=%b expected=%b", n, bus.frame_done, efd);
        end
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        bus.digits     = d;
        bus.dp_mask    = dp;
        bus.blink_mask = bl;
        bus.lz_en      = lz;
        bus.load       = 1'b1;
        step();
        bus.load       = 1'b0;
    endtask

    task automatic set_bright(input logic [3:0] b);
        bright         = b;
        bus.brightness = b;
    endtask

    task automatic run_until_phase(input int target);
        while (n % FRAME != target) step();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.load = 1'b0;
        #1;
        checks++;
        assert (bus.fnd_font === 8'hFF) else begin
            failures++;
            $error("FAIL reset_font observed=%h expected=ff", bus.fnd_font);
        end
        checks++;
        assert (bus.fnd_comm === 4'hF) else begin
            failures++;
            $error("FAIL reset_comm observed=%b expected=1111", bus.fnd_comm);
        end
        checks++;
        assert (bus.frame_done === 1'b0) else begin
            failures++;
            $error("FAIL reset_frame_done observed=%b expected=0", bus.frame_done);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n     = 0;
        log_q.delete();
    endtask

    initial begin
        logic [15:0] rd;
        bus.digits     = '0;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.lz_en      = 1'b0;
        bus.load       = 1'b0;
        set_bright(4'hF);
        #1;

        // 1: reset, no load: dark pins, frame_done every 640 clk
        do_reset();
        run(2 * FRAME + 20);

        // 2: 1234 with dp on digit 2, full brightness
        do_load(16'h1234, 4'b0100, 4'b0000, 1'b0);
        run(2 * FRAME);

        // 3: leading-zero suppression on, then off
        do_load(16'h0070, 4'b0000, 4'b0000, 1'b1);
        run(2 * FRAME);
        do_load(16'h0070, 4'b0000, 4'b0000, 1'b0);
        run(2 * FRAME);

        // 4: minimum brightness
        set_bright(4'h0);
        run(FRAME + 30);
        set_bright(4'h7);
        run(FRAME);
        set_bright(4'hF);

        // 5: blink on digit 0
        do_load(16'h0005, 4'b0000, 4'b0001, 1'b0);
        run(4 * PHASE);

        // 6: last load wins, and loads around the commit clock
        run_until_phase(300);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        run(4);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        run(FRAME + 10);
        run_until_phase(FRAME - 1);
        do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        run(FRAME + 20);
        run_until_phase(0);
        do_load(16'h4444, 4'b1111, 4'b0000, 1'b0);
        run(FRAME + 20);
        run_until_phase(FRAME - 2);
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
        do_load(16'h9012, 4'b0000, 4'b0000, 1'b0);
        run(2 * FRAME);

        // 7: randomized data, masks, brightness and load spacing
        for (int r = 0; r < 8; r++) begin
            rd = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) rd[4*k +: 4] = 4'h0;
            set_bright(4'($urandom_range(0, 15)));
            do_load(rd, 4'($urandom), 4'($urandom), 1'($urandom));
            run($urandom_range(50, 1500));
        end

        // 8: reset mid-frame discards pending data
        set_bright(4'hF);
        run_until_phase(200);
        do_load(16'h8888, 4'b0000, 4'b0000, 1'b0);
        run(7);
        do_reset();
        run(FRAME + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
